io_frame_mover: RTL



---
 rtl/io_frame_mover.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/io_frame_mover.sv
// -----------------------------------------------------------------------------
// io_frame_mover
//
// Once per audio frame this block moves every input slot from the io bus into
// sample memory (sign-extended and scaled up), then moves the output samples
// from sample memory back to the io bus (scaled down with saturation).
//
// Sequence per frame_tick (accepted only in IDLE):
//   IN   : NUM_CH+1 cycles. Cycle c issues io read c (c < NUM_CH) and writes
//          the data returned for read c-1 into IN_BASE+c-1 (c >= 1).
//   OUT  : NUM_CH+1 cycles. Cycle c issues sample read OUT_BASE+c and writes
//          the narrowed result of read c-1 to io slot c-1.
//   DONE : one cycle, pulses done.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   frame_tick          one-cycle frame start pulse
//   clear_overrun       clears overrun (and sat_count when enabled)
//   busy, done          transfer in progress / end-of-frame pulse
//   overrun             sticky: tick arrived while not idle
//   sat_count           clipped-output counter (0 unless feature enabled)
//   io_rd_*             io input-slot read port (1-cycle read latency)
//   io_wr_*             io output-slot write port
//   sample_rd_*         sample memory read port (1-cycle read latency)
//   sample_wr_*         sample memory write port
//
// Optional feature macro: IO_FRAME_MOVER_SAT_COUNT_EN
//   defined   : sat_count counts clamped io writes, saturating at 0xFFFF
//   undefined : sat_count is tied to zero
// -----------------------------------------------------------------------------
module io_frame_mover #(
  parameter int unsigned SAMPLE_WIDTH      = 36,
  parameter int unsigned SAMPLE_ADDR_WIDTH = 10,
  parameter int unsigned IO_WIDTH          = 24,
  parameter int unsigned IO_ADDR_WIDTH     = 10,
  parameter int unsigned NUM_CH            = 8,
  parameter int unsigned IN_BASE           = 0,
  parameter int unsigned OUT_BASE          = 8,
  parameter int unsigned IN_SHIFT          = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic                         clear_overrun,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun,
  output logic [15:0]                  sat_count,
  output logic [IO_ADDR_WIDTH-1:0]     io_rd_addr,
  output logic                         io_rd_en,
  input  logic [IO_WIDTH-1:0]          io_rd_data,
  output logic [IO_ADDR_WIDTH-1:0]     io_wr_addr,
  output logic                         io_wr_en,
  output logic [IO_WIDTH-1:0]          io_wr_data,
  output logic [SAMPLE_ADDR_WIDTH-1:0] sample_rd_addr,
  output logic                         sample_rd_en,
  input  logic [SAMPLE_WIDTH-1:0]      sample_rd_data,
  output logic [SAMPLE_ADDR_WIDTH-1:0] sample_wr_addr,
  output logic                         sample_wr_en,
  output logic [SAMPLE_WIDTH-1:0]      sample_wr_data
);

  // Counter must reach NUM_CH inclusive (the drain cycle of each phase).
  localparam int unsigned CNT_W = $clog2(NUM_CH + 1);

  // Largest / smallest value representable on the io bus, in sample width.
  // ~IO_MAX is exactly -IO_MAX-1 in two's complement.
  localparam logic signed [SAMPLE_WIDTH-1:0] IO_MAX =
    SAMPLE_WIDTH'({1'b0, {(IO_WIDTH-1){1'b1}}});
  localparam logic signed [SAMPLE_WIDTH-1:0] IO_MIN = ~IO_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IN   = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Data transforms
  // ---------------------------------------------------------------------------

  // Sign-extend an io word to sample width, then scale up; overflow discarded.
  function automatic logic [SAMPLE_WIDTH-1:0] widen(input logic [IO_WIDTH-1:0] x);
    logic signed [IO_WIDTH-1:0]     xs;
    logic signed [SAMPLE_WIDTH-1:0] ext;
    xs  = x;
    ext = SAMPLE_WIDTH'(xs);
    return ext << IN_SHIFT;
  endfunction

  // Floor-scale a sample down and clamp it to the io range.
  function automatic logic [IO_WIDTH-1:0] narrow(input logic [SAMPLE_WIDTH-1:0] s);
    logic signed [SAMPLE_WIDTH-1:0] sh;
    sh = signed'(s) >>> IN_SHIFT;
    if (sh > IO_MAX) begin
      return {1'b0, {(IO_WIDTH-1){1'b1}}};
    end else if (sh < IO_MIN) begin
      return {1'b1, {(IO_WIDTH-1){1'b0}}};
    end else begin
      return sh[IO_WIDTH-1:0];
    end
  endfunction

  // True when narrow() would clamp this sample.
  function automatic logic narrow_clips(input logic [SAMPLE_WIDTH-1:0] s);
    logic signed [SAMPLE_WIDTH-1:0] sh;
    sh = signed'(s) >>> IN_SHIFT;
    return (sh > IO_MAX) || (sh < IO_MIN);
  endfunction

  // Base plus zero-extended counter, wrapping modulo the sample address space.
  function automatic logic [SAMPLE_ADDR_WIDTH-1:0] smp_addr(input int unsigned base,
                                                            input logic [CNT_W-1:0] c);
    return SAMPLE_ADDR_WIDTH'(base + 32'(c));
  endfunction

  // Zero-extended counter as an io channel index.
  function automatic logic [IO_ADDR_WIDTH-1:0] io_addr(input logic [CNT_W-1:0] c);
    return IO_ADDR_WIDTH'(32'(c));
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t                         state_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [CNT_W-1:0]               cnt_d;
  logic                           cnt_last_d;
  logic                           more_d;

  logic                           busy_q;
  logic                           done_q;
  logic                           overrun_q;
  logic                           io_rd_en_q;
  logic [IO_ADDR_WIDTH-1:0]       io_rd_addr_q;
  logic                           io_wr_en_q;
  logic [IO_ADDR_WIDTH-1:0]       io_wr_addr_q;
  logic                           sample_rd_en_q;
  logic [SAMPLE_ADDR_WIDTH-1:0]   sample_rd_addr_q;
  logic                           sample_wr_en_q;
  logic [SAMPLE_ADDR_WIDTH-1:0]   sample_wr_addr_q;

  // Counter arithmetic shared by both transfer phases.
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    cnt_last_d = (32'(cnt_q) == NUM_CH);
    more_d     = (32'(cnt_d) < NUM_CH);
  end

  // Frame FSM. Strobes and addresses are computed for the state being entered
  // so they appear in the same cycle as that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      overrun_q        <= 1'b0;
      io_rd_en_q       <= 1'b0;
      io_rd_addr_q     <= '0;
      io_wr_en_q       <= 1'b0;
      io_wr_addr_q     <= '0;
      sample_rd_en_q   <= 1'b0;
      sample_rd_addr_q <= '0;
      sample_wr_en_q   <= 1'b0;
      sample_wr_addr_q <= '0;
    end else begin
      done_q           <= 1'b0;
      io_rd_en_q       <= 1'b0;
      io_rd_addr_q     <= '0;
      io_wr_en_q       <= 1'b0;
      io_wr_addr_q     <= '0;
      sample_rd_en_q   <= 1'b0;
      sample_rd_addr_q <= '0;
      sample_wr_en_q   <= 1'b0;
      sample_wr_addr_q <= '0;

      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            state_q      <= ST_IN;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            io_rd_en_q   <= 1'b1;
            io_rd_addr_q <= io_addr('0);
          end else begin
            busy_q       <= 1'b0;
          end
        end

        ST_IN: begin
          if (cnt_last_d) begin
            state_q          <= ST_OUT;
            cnt_q            <= '0;
            sample_rd_en_q   <= 1'b1;
            sample_rd_addr_q <= smp_addr(OUT_BASE, '0);
          end else begin
            cnt_q            <= cnt_d;
            io_rd_en_q       <= more_d;
            io_rd_addr_q     <= more_d ? io_addr(cnt_d) : '0;
            // Next cycle's data belongs to the read issued at cnt_q.
            sample_wr_en_q   <= 1'b1;
            sample_wr_addr_q <= smp_addr(IN_BASE, cnt_q);
          end
        end

        ST_OUT: begin
          if (cnt_last_d) begin
            state_q          <= ST_DONE;
            cnt_q            <= '0;
            done_q           <= 1'b1;
          end else begin
            cnt_q            <= cnt_d;
            sample_rd_en_q   <= more_d;
            sample_rd_addr_q <= more_d ? smp_addr(OUT_BASE, cnt_d) : '0;
            io_wr_en_q       <= 1'b1;
            io_wr_addr_q     <= io_addr(cnt_q);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase

      // A tick outside IDLE (including the DONE cycle) is dropped; set beats clear.
      if (frame_tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun) begin
        overrun_q <= 1'b0;
      end else begin
        overrun_q <= overrun_q;
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign overrun        = overrun_q;
  assign io_rd_en       = io_rd_en_q;
  assign io_rd_addr     = io_rd_addr_q;
  assign io_wr_en       = io_wr_en_q;
  assign io_wr_addr     = io_wr_addr_q;
  assign sample_rd_en   = sample_rd_en_q;
  assign sample_rd_addr = sample_rd_addr_q;
  assign sample_wr_en   = sample_wr_en_q;
  assign sample_wr_addr = sample_wr_addr_q;

  // The read data buses are already registered inside the bus memories, so the
  // write data is a pure transform of that registered data, gated by the
  // registered strobe so idle cycles present zero.
  assign sample_wr_data = sample_wr_en_q ? widen(io_rd_data)      : '0;
  assign io_wr_data     = io_wr_en_q     ? narrow(sample_rd_data) : '0;

`ifdef IO_FRAME_MOVER_SAT_COUNT_EN
  logic [15:0] sat_count_q;

  // Count clamped io writes, holding at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count_q <= 16'h0000;
    end else if (clear_overrun) begin
      sat_count_q <= 16'h0000;
    end else if (io_wr_en_q && narrow_clips(sample_rd_data) && (sat_count_q != 16'hFFFF)) begin
      sat_count_q <= sat_count_q + 16'h0001;
    end else begin
      sat_count_q <= sat_count_q;
    end
  end

  assign sat_count = sat_count_q;
`else
  assign sat_count = 16'h0000;
`endif

endmodule
